sdr_upload_streamer: RTL and testbench
======================================

// Module: sdr_upload_streamer
// PURPOSE
//  Read side of the ROM download path. Streams a byte range out of SDRAM into
//  the data_io upload interface (ioctl_upload / ioctl_rd / ioctl_din), e.g. for
//  high-score or NVRAM save. Sits in the core top beside rom_loader and shares
//  its SDRAM toggle req/ack port through an external mux. It is the reverse
//  direction of rom_loader: it reads SDRAM and emits bytes.
// PARAMETERS
//  ADDR_W   25  byte-address and length width
// PORTS
//  CLK_32M      in   1   sole clock
//  reset        in   1   asynchronous, active-high reset
//  start        in   1   1-cycle pulse: begin upload; accepted only in IDLE
//  base_addr    in   25  first byte address in SDRAM
//  length       in   25  number of bytes to upload
//  busy         out  1   high from accepted start until done
//  done         out  1   1-cycle pulse when the last byte has been consumed
//  ioctl_upload out  1   high while bytes remain to be streamed
//  ioctl_rd     in   1   1-cycle strobe: host consumed the current byte
//  ioctl_din    out  8   current byte
//  ioctl_wait   out  1   high while bytes remain but none is buffered
//  sdr_addr     out  24  SDRAM word address, [24:1]
//  sdr_req      out  1   toggle handshake: invert to request one 16-bit read
//  sdr_ack      in   1   request complete when sdr_ack == sdr_req
//  sdr_data     in   16  read word, valid on the completing cycle
// BEHAVIOUR
//  Reset values: every output is 0, the FIFO is empty and the state is IDLE.
//  Handshake and byte order:
//  - sdr_ack is CLK_32M-synchronous.
//  - Byte order is little-endian: even address = sdr_data[7:0], odd = [15:8].
//  States:
//  - IDLE: sdr_req <= sdr_ack every cycle. This absorbs a request still in
//    flight across reset without ever re-issuing it.
//    On start with length==0: done pulses next cycle; ioctl_upload stays 0.
//    On start with length!=0: latch the byte pointer and words_left =
//    (base_addr[0] + length + 1) >> 1; set byte_sel = base_addr[0];
//    go to STREAM. busy and ioctl_upload rise the cycle after start.
//  - STREAM (fetcher): at most one request is outstanding at a time. Issue a
//    request when words_left != 0 and (FIFO entries + outstanding) < 2. On
//    issue: drive sdr_addr, toggle sdr_req, advance the word address,
//    decrement words_left. When ack == req, push sdr_data into the FIFO; the
//    word is visible on ioctl_din the next cycle.
//  - STREAM (drain): ioctl_din = FIFO head byte selected by byte_sel.
//    ioctl_wait = FIFO empty. An ioctl_rd while ioctl_wait=1 is ignored (no
//    advance, no error state). A valid ioctl_rd decrements bytes_left and
//    toggles byte_sel; the head pops when byte_sel was 1 or this is the
//    last byte.
//  - When bytes_left reaches 0: ioctl_upload falls, done pulses, busy falls,
//    next state IDLE. All three outputs change on the same cycle.
//  Boundary rules:
//  - start while busy is ignored.
//  - A push and a pop on the same cycle keeps occupancy unchanged.
//  - The word address wraps at 2^24 with no special handling.
//  - The word count is exact, so no request is ever outstanding at DONE.
//  - Reset mid-transfer aborts immediately. No done pulse is emitted and no
//    stray byte is produced.
// STRUCTURE
//  - m72_pkg: add typedef enum logic [1:0] {UPL_IDLE, UPL_STREAM} upl_state_t
//    and localparam UPL_FIFO_DEPTH = 2.
//  - One sub-module, upl_word_fifo: a 2x16 register FIFO with push, pop,
//    count and head outputs, same async reset.
//  - The top level holds the counters, the state register and the handshake.
// TESTING
//  1. Full words: SDRAM model holds 0x100000=16'hBBAA and
//     0x100002=16'hDDCC; start base 0x100000, len 4 -> sdr_addr 0x080000
//     then 0x080001; ioctl_din AA,BB,CC,DD; done after the 4th rd.
//  2. Odd start: same memory, base 0x100001, len 3 -> two requests;
//     ioctl_din BB,CC,DD; ioctl_upload low on the cycle after the 3rd rd.
//  3. Zero length: start with len 0 -> done high exactly 1 cycle;
//     ioctl_upload and busy stay 0; sdr_req never toggles.
//  4. Slow SDRAM: ack delayed 40 cycles -> ioctl_wait=1 while empty; rd
//     strobes during wait are ignored; a 6-byte transfer delivers all bytes
//     in order.
//  5. Reset in flight: reset while a request is outstanding, ack toggles 5
//     cycles after release -> no new req toggle; a following start (len 2)
//     completes normally.
//  6. Start while busy: a second start mid-transfer -> ignored; base and
//     length are unchanged; exactly one done pulse.

Source files
------------

// File: rtl/sdr_upload_streamer_pkg.sv
// Shared types and constants for the SDRAM upload streamer.
package sdr_upload_streamer_pkg;

  localparam int UPL_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    UPL_IDLE   = 2'd0,
    UPL_STREAM = 2'd1
  } upl_state_t;

  // Little-endian byte lane select: sel=0 -> low byte (even address), sel=1 -> high byte.
  function automatic logic [7:0] upl_pick_byte(input logic [15:0] word, input logic sel);
    return sel ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sdr_upload_streamer_word_fifo.sv
// Two-entry 16-bit register FIFO holding SDRAM words waiting to be drained as bytes.
module upl_word_fifo
  import sdr_upload_streamer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [15:0] i_data,
  output logic [1:0]  o_count,
  output logic [15:0] o_head
);

  logic [15:0] r_mem [0:UPL_FIFO_DEPTH-1];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_do_push;
  logic        w_do_pop;

  // A push into a full FIFO is only legal when the head leaves on the same cycle.
  assign w_do_push = i_push && ((r_count != 2'd2) || i_pop);
  assign w_do_pop  = i_pop && (r_count != 2'd0);

  // Storage, pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= 16'h0000;
      r_mem[1] <= 16'h0000;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/sdr_upload_streamer.sv
// Streams a byte range out of SDRAM into the data_io upload interface.
module sdr_upload_streamer
  import sdr_upload_streamer_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic              CLK_32M,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              ioctl_upload,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-2:0] sdr_addr,
  output logic              sdr_req,
  input  logic              sdr_ack,
  input  logic [15:0]       sdr_data
);

  upl_state_t        r_state;
  upl_state_t        w_state_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_upload;
  logic              r_sdr_req;
  logic              r_outstanding;
  logic              r_byte_sel;
  logic [ADDR_W-2:0] r_sdr_addr;
  logic [ADDR_W-2:0] r_word_addr;
  logic [ADDR_W-1:0] r_words_left;
  logic [ADDR_W-1:0] r_bytes_left;

  logic              w_streaming;
  logic              w_len_zero;
  logic [ADDR_W-1:0] w_words_init;
  logic              w_ack_done;
  logic              w_issue;
  logic              w_rd_ok;
  logic              w_last;
  logic              w_pop;
  logic [1:0]        w_fifo_count;
  logic [15:0]       w_fifo_head;
  logic              w_fifo_empty;

  assign w_streaming  = (r_state == UPL_STREAM);
  assign w_len_zero   = (length == {ADDR_W{1'b0}});
  // (base[0] + len + 1) >> 1 without a carry bit: an odd start or odd length adds one word.
  assign w_words_init = {1'b0, length[ADDR_W-1:1]} + {{(ADDR_W-1){1'b0}}, (base_addr[0] | length[0])};
  assign w_fifo_empty = (w_fifo_count == 2'd0);
  assign w_ack_done   = w_streaming && r_outstanding && (sdr_ack == r_sdr_req);
  // Single outstanding request; with none in flight the slot check reduces to a free FIFO entry.
  assign w_issue      = w_streaming && !r_outstanding &&
                        (r_words_left != {ADDR_W{1'b0}}) && (w_fifo_count < 2'd2);
  assign w_rd_ok      = w_streaming && ioctl_rd && !w_fifo_empty;
  assign w_last       = w_rd_ok && (r_bytes_left == {{(ADDR_W-1){1'b0}}, 1'b1});
  assign w_pop        = w_rd_ok && (r_byte_sel || w_last);

  upl_word_fifo u_fifo (
    .i_clk   (CLK_32M),
    .i_rst   (reset),
    .i_push  (w_ack_done),
    .i_pop   (w_pop),
    .i_data  (sdr_data),
    .o_count (w_fifo_count),
    .o_head  (w_fifo_head)
  );

  // State register.
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      r_state <= UPL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: enter STREAM on a non-empty start, leave on the last consumed byte.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      UPL_IDLE: begin
        if (start && !w_len_zero) begin
          w_state_nxt = UPL_STREAM;
        end else begin
          w_state_nxt = UPL_IDLE;
        end
      end
      UPL_STREAM: begin
        if (w_last) begin
          w_state_nxt = UPL_IDLE;
        end else begin
          w_state_nxt = UPL_STREAM;
        end
      end
      default: w_state_nxt = UPL_IDLE;
    endcase
  end

  // Counters, SDRAM handshake and status flags.
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_upload      <= 1'b0;
      r_sdr_req     <= 1'b0;
      r_outstanding <= 1'b0;
      r_byte_sel    <= 1'b0;
      r_sdr_addr    <= {(ADDR_W-1){1'b0}};
      r_word_addr   <= {(ADDR_W-1){1'b0}};
      r_words_left  <= {ADDR_W{1'b0}};
      r_bytes_left  <= {ADDR_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      if (r_state == UPL_IDLE) begin
        // Tracking ack swallows any request left in flight across reset.
        r_sdr_req     <= sdr_ack;
        r_outstanding <= 1'b0;
        if (start) begin
          if (w_len_zero) begin
            r_done <= 1'b1;
          end else begin
            r_word_addr  <= base_addr[ADDR_W-1:1];
            r_words_left <= w_words_init;
            r_bytes_left <= length;
            r_byte_sel   <= base_addr[0];
            r_busy       <= 1'b1;
            r_upload     <= 1'b1;
          end
        end
      end else begin
        if (w_issue) begin
          r_sdr_addr    <= r_word_addr;
          r_sdr_req     <= ~r_sdr_req;
          r_word_addr   <= r_word_addr + {{(ADDR_W-2){1'b0}}, 1'b1};
          r_words_left  <= r_words_left - {{(ADDR_W-1){1'b0}}, 1'b1};
          r_outstanding <= 1'b1;
        end else if (w_ack_done) begin
          r_outstanding <= 1'b0;
        end
        if (w_rd_ok) begin
          r_bytes_left <= r_bytes_left - {{(ADDR_W-1){1'b0}}, 1'b1};
          r_byte_sel   <= ~r_byte_sel;
        end
        if (w_last) begin
          r_busy   <= 1'b0;
          r_upload <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign ioctl_upload = r_upload;
  assign sdr_req      = r_sdr_req;
  assign sdr_addr     = r_sdr_addr;
  assign ioctl_wait   = w_streaming && w_fifo_empty;
  assign ioctl_din    = (w_streaming && !w_fifo_empty) ? upl_pick_byte(w_fifo_head, r_byte_sel) : 8'h00;

endmodule

// File: tb/tb_sdr_upload_streamer.sv
// Directed bench for sdr_upload_streamer with a toggle-handshake SDRAM model.
module tb_sdr_upload_streamer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [24:0] base_addr;
  logic [24:0] length;
  logic        busy;
  logic        done;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [23:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_ack;
  logic [15:0] sdr_data;

  int vectors    = 0;
  int miscompares = 0;
  int done_cnt   = 0;

  // SDRAM model state.
  int          model_delay = 1;
  bit          model_en    = 1'b1;
  bit          m_pending   = 1'b0;
  int          m_cnt       = 0;
  logic [23:0] m_addr;
  logic [23:0] req_log [$];

  sdr_upload_streamer #(.ADDR_W(25)) dut (
    .CLK_32M      (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .sdr_addr     (sdr_addr),
    .sdr_req      (sdr_req),
    .sdr_ack      (sdr_ack),
    .sdr_data     (sdr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    case (a)
      24'h080000: return 16'hBBAA;
      24'h080001: return 16'hDDCC;
      24'h080002: return 16'hFFEE;
      default:    return 16'h0000;
    endcase
  endfunction

  // SDRAM responder: sees a new request when req differs from ack, answers after model_delay cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!model_en) begin
        m_pending = 1'b0;
      end else if (!m_pending) begin
        if (sdr_req !== sdr_ack) begin
          m_pending = 1'b1;
          m_cnt     = model_delay;
          m_addr    = sdr_addr;
          req_log.push_back(sdr_addr);
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt <= 0) begin
          sdr_data  = mem_word(m_addr);
          sdr_ack   = sdr_req;
          m_pending = 1'b0;
        end
      end
    end
  end

  // Count every done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [24:0] b, input logic [24:0] l);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_rd();
    ioctl_rd = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
  endtask

  task automatic read_byte(input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    while (((ioctl_wait !== 1'b0) || (ioctl_upload !== 1'b1)) && (n < 200)) begin
      @(negedge clk);
      n = n + 1;
    end
    check({tag, "_timeout"}, (n < 200) ? 32'd1 : 32'd0, 32'd1);
    check(tag, {24'd0, ioctl_din}, {24'd0, exp});
    pulse_rd();
  endtask

  task automatic finish_check(input string tag);
    check({tag, "_done"},   {31'd0, done},         32'd1);
    check({tag, "_busy"},   {31'd0, busy},         32'd0);
    check({tag, "_upload"}, {31'd0, ioctl_upload}, 32'd0);
    @(negedge clk);
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n0;
    int dc0;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = 25'd0;
    length    = 25'd0;
    ioctl_rd  = 1'b0;
    sdr_ack   = 1'b0;
    sdr_data  = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",   {31'd0, busy},         32'd0);
    check("rst_done",   {31'd0, done},         32'd0);
    check("rst_upload", {31'd0, ioctl_upload}, 32'd0);
    check("rst_wait",   {31'd0, ioctl_wait},   32'd0);
    check("rst_din",    {24'd0, ioctl_din},    32'd0);
    check("rst_req",    {31'd0, sdr_req},      32'd0);
    check("rst_addr",   {8'd0, sdr_addr},      32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1. Full words, even base
    n0 = req_log.size();
    start_xfer(25'h100000, 25'd4);
    check("t1_busy",   {31'd0, busy},         32'd1);
    check("t1_upload", {31'd0, ioctl_upload}, 32'd1);
    check("t1_wait",   {31'd0, ioctl_wait},   32'd1);
    read_byte(8'hAA, "t1_b0");
    read_byte(8'hBB, "t1_b1");
    read_byte(8'hCC, "t1_b2");
    read_byte(8'hDD, "t1_b3");
    finish_check("t1");
    check("t1_nreq", req_log.size() - n0, 32'd2);
    check("t1_a0", {8'd0, req_log[n0]},     32'h080000);
    check("t1_a1", {8'd0, req_log[n0 + 1]}, 32'h080001);

    // 2. Odd start address
    n0 = req_log.size();
    start_xfer(25'h100001, 25'd3);
    read_byte(8'hBB, "t2_b0");
    read_byte(8'hCC, "t2_b1");
    read_byte(8'hDD, "t2_b2");
    finish_check("t2");
    check("t2_nreq", req_log.size() - n0, 32'd2);
    check("t2_a0", {8'd0, req_log[n0]},     32'h080000);
    check("t2_a1", {8'd0, req_log[n0 + 1]}, 32'h080001);

    // 3. Zero length
    n0 = req_log.size();
    start_xfer(25'h100000, 25'd0);
    check("t3_done",   {31'd0, done},         32'd1);
    check("t3_busy",   {31'd0, busy},         32'd0);
    check("t3_upload", {31'd0, ioctl_upload}, 32'd0);
    @(negedge clk);
    check("t3_done_low", {31'd0, done},         32'd0);
    check("t3_upload2",  {31'd0, ioctl_upload}, 32'd0);
    check("t3_nreq",     req_log.size() - n0,   32'd0);
    check("t3_req_eq",   {31'd0, sdr_req ^ sdr_ack}, 32'd0);

    // 4. Slow SDRAM, reads during wait are ignored
    model_delay = 40;
    start_xfer(25'h100000, 25'd6);
    repeat (3) @(negedge clk);
    check("t4_wait", {31'd0, ioctl_wait}, 32'd1);
    pulse_rd();
    @(negedge clk);
    pulse_rd();
    check("t4_wait2",  {31'd0, ioctl_wait},   32'd1);
    check("t4_upload", {31'd0, ioctl_upload}, 32'd1);
    read_byte(8'hAA, "t4_b0");
    read_byte(8'hBB, "t4_b1");
    read_byte(8'hCC, "t4_b2");
    read_byte(8'hDD, "t4_b3");
    read_byte(8'hEE, "t4_b4");
    read_byte(8'hFF, "t4_b5");
    finish_check("t4");
    model_delay = 1;

    // 5. Reset with a request in flight
    model_en = 1'b0;
    dc0 = done_cnt;
    start_xfer(25'h100000, 25'd2);
    @(negedge clk);
    check("t5_req_out", {31'd0, sdr_req ^ sdr_ack}, 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_rst_upload", {31'd0, ioctl_upload}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_pre_eq", {31'd0, sdr_req ^ sdr_ack}, 32'd0);
    end
    sdr_ack  = ~sdr_ack;
    sdr_data = 16'h1234;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("t5_post_eq", {31'd0, sdr_req ^ sdr_ack}, 32'd0);
      check("t5_upload",  {31'd0, ioctl_upload},      32'd0);
      check("t5_wait",    {31'd0, ioctl_wait},        32'd0);
      @(negedge clk);
    end
    check("t5_no_done", done_cnt - dc0, 32'd0);
    model_en = 1'b1;
    @(negedge clk);
    start_xfer(25'h100000, 25'd2);
    read_byte(8'hAA, "t5_b0");
    read_byte(8'hBB, "t5_b1");
    finish_check("t5");

    // 6. Start while busy is ignored
    repeat (2) @(negedge clk);
    dc0 = done_cnt;
    n0  = req_log.size();
    start_xfer(25'h100000, 25'd4);
    read_byte(8'hAA, "t6_b0");
    start_xfer(25'h000200, 25'd1);
    check("t6_busy", {31'd0, busy}, 32'd1);
    read_byte(8'hBB, "t6_b1");
    read_byte(8'hCC, "t6_b2");
    read_byte(8'hDD, "t6_b3");
    finish_check("t6");
    repeat (3) @(negedge clk);
    check("t6_ndone", done_cnt - dc0, 32'd1);
    check("t6_nreq",  req_log.size() - n0, 32'd2);
    check("t6_a0", {8'd0, req_log[n0]},     32'h080000);
    check("t6_a1", {8'd0, req_log[n0 + 1]}, 32'h080001);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
